// File: rtl/axi_lite_sram_responder_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// handshake FSM states and the default memory base address.
package axi_lite_sram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Also the core's PC reset value, so fetch starts at the first mapped word.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axi_lite_sram_responder_sram_word_array.sv
// Word-addressed storage with byte-enable writes and combinational read.
// Contents are deliberately left unreset so a preloaded image survives reset.
module sram_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] w_bit_mask;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
      assign w_bit_mask[gi*8 +: 8] = {8{i_wstrb[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_idx] <= (r_mem[i_wr_idx] & ~w_bit_mask) | (i_wdata & w_bit_mask);
    end
  end

  assign o_rdata = r_mem[i_rd_idx];

endmodule

// File: rtl/axi_lite_sram_responder.sv
// AXI4-Lite slave over an SRAM word array with configurable read/write latency.
// One transaction in flight at a time; reads win over a simultaneous write.
module axi_lite_sram_responder
  import axi_lite_sram_responder_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                RD_LAT      = 1,
  parameter int                WR_LAT      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [DATA_W-1:0]    rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W/8-1:0]  wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_oob;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [DATA_W-1:0]     r_rdata;
  logic [1:0]            r_rresp, r_bresp;

  logic [ADDR_W-1:0]     w_req_addr, w_off;
  logic                  w_req_oob, w_idle, w_ar_hs, w_wr_hs;
  logic [IDX_W-1:0]      w_req_idx, w_cur_idx;
  logic                  w_cur_oob, w_enter_rd_resp, w_enter_wr_resp, w_we;
  logic [DATA_W-1:0]     w_wr_data, w_mem_rdata;
  logic [DATA_W/8-1:0]   w_wr_strb;

  // Unsigned offset; addresses below the base wrap high and are caught explicitly.
  assign w_req_addr = arvalid ? araddr : awaddr;
  assign w_off      = w_req_addr - BASE_ADDR;
  assign w_req_oob  = (w_req_addr < BASE_ADDR) || ((w_off >> 2) >= ADDR_W'(DEPTH_WORDS));
  assign w_req_idx  = w_off[IDX_W+1:2];

  assign w_idle  = (r_state == IDLE) && rst;
  assign arready = w_idle;
  assign awready = w_idle && awvalid && wvalid && !arvalid;
  assign wready  = awready;
  assign w_ar_hs = arready && arvalid;
  assign w_wr_hs = awready;

  assign rvalid = (r_state == RD_RESP);
  assign bvalid = (r_state == WR_RESP);
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign bresp  = r_bresp;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_ar_hs) begin
          w_state_next = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
          w_cnt_next   = CNT_W'(RD_LAT - 1);
        end else if (w_wr_hs) begin
          w_state_next = (WR_LAT == 1) ? WR_RESP : WR_WAIT;
          w_cnt_next   = CNT_W'(WR_LAT - 1);
        end
      end
      RD_WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = RD_RESP;
      end
      RD_RESP: if (rready) w_state_next = IDLE;
      WR_WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = WR_RESP;
      end
      WR_RESP: if (bready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With unit latency the response is produced straight from the request inputs.
  assign w_cur_idx       = (r_state == IDLE) ? w_req_idx : r_idx;
  assign w_cur_oob       = (r_state == IDLE) ? w_req_oob : r_oob;
  assign w_wr_data       = (r_state == IDLE) ? wdata : r_wdata;
  assign w_wr_strb       = (r_state == IDLE) ? wstrb : r_wstrb;
  assign w_enter_rd_resp = (w_state_next == RD_RESP) && (r_state != RD_RESP);
  assign w_enter_wr_resp = (w_state_next == WR_RESP) && (r_state != WR_RESP);
  assign w_we            = w_enter_wr_resp && !w_cur_oob;

  sram_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .DATA_W      (DATA_W)
  ) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_wr_idx (w_cur_idx),
    .i_wstrb  (w_wr_strb),
    .i_wdata  (w_wr_data),
    .i_rd_idx (w_cur_idx),
    .o_rdata  (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_oob   <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_bresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_ar_hs || w_wr_hs) begin
        r_idx   <= w_req_idx;
        r_oob   <= w_req_oob;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_enter_rd_resp) begin
        r_rdata <= w_cur_oob ? '0 : w_mem_rdata;
        r_rresp <= w_cur_oob ? RESP_DECERR : RESP_OKAY;
      end
      if (w_enter_wr_resp) begin
        r_bresp <= w_cur_oob ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Directed bench: instance A uses unit latencies, instance B uses RD_LAT=4/WR_LAT=2.
module tb_axi_lite_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance A signals
  logic        a_rst, a_arvalid, a_arready, a_rvalid, a_rready;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic [31:0] a_araddr, a_awaddr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_rresp, a_bresp;

  // Instance B signals
  logic        b_rst, b_arvalid, b_arready, b_rvalid, b_rready;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic [31:0] b_araddr, b_awaddr, b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic [1:0]  b_rresp, b_bresp;

  axi_lite_sram_responder #(.RD_LAT(1), .WR_LAT(1)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .araddr(a_araddr), .arvalid(a_arvalid), .arready(a_arready),
    .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(a_rready),
    .awaddr(a_awaddr), .awvalid(a_awvalid), .awready(a_awready),
    .wdata(a_wdata), .wstrb(a_wstrb), .wvalid(a_wvalid), .wready(a_wready),
    .bresp(a_bresp), .bvalid(a_bvalid), .bready(a_bready)
  );

  axi_lite_sram_responder #(.RD_LAT(4), .WR_LAT(2)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
    .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
    .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(b_awready),
    .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(b_wready),
    .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic a_write(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int n;
    a_awaddr = addr; a_wdata = data; a_wstrb = strb;
    a_awvalid = 1'b1; a_wvalid = 1'b1;
    n = 0;
    while (!a_awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    lat = 1;
    while (!a_bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    resp = a_bresp;
    @(posedge clk); #1;
    $display("A write addr=%h data=%h strb=%b bresp=%b lat=%0d", addr, data, strb, resp, lat);
  endtask

  task automatic a_read(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output int lat);
    int n;
    a_araddr = addr; a_arvalid = 1'b1;
    n = 0;
    while (!a_arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_arvalid = 1'b0;
    lat = 1;
    while (!a_rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    data = a_rdata; resp = a_rresp;
    @(posedge clk); #1;
    $display("A read  addr=%h rdata=%h rresp=%b lat=%0d", addr, data, resp, lat);
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    b_awaddr = addr; b_wdata = data; b_wstrb = 4'hF;
    b_awvalid = 1'b1; b_wvalid = 1'b1;
    n = 0;
    while (!b_awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b_awvalid = 1'b0; b_wvalid = 1'b0;
    lat = 1;
    while (!b_bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    resp = b_bresp;
    @(posedge clk); #1;
    $display("B write addr=%h data=%h bresp=%b lat=%0d", addr, data, resp, lat);
  endtask

  task automatic b_read(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output int lat);
    int n;
    b_araddr = addr; b_arvalid = 1'b1;
    n = 0;
    while (!b_arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b_arvalid = 1'b0;
    lat = 1;
    while (!b_rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    data = b_rdata; resp = b_rresp;
    @(posedge clk); #1;
    $display("B read  addr=%h rdata=%h rresp=%b lat=%0d", addr, data, resp, lat);
  endtask

  logic [31:0] rd, held;
  logic [1:0]  rs;
  int          lat;
  logic        saw_rvalid;

  initial begin
    a_rst = 1'b0; a_arvalid = 1'b0; a_awvalid = 1'b0; a_wvalid = 1'b0;
    a_rready = 1'b1; a_bready = 1'b1;
    a_araddr = '0; a_awaddr = '0; a_wdata = '0; a_wstrb = '0;
    b_rst = 1'b0; b_arvalid = 1'b0; b_awvalid = 1'b0; b_wvalid = 1'b0;
    b_rready = 1'b1; b_bready = 1'b1;
    b_araddr = '0; b_awaddr = '0; b_wdata = '0; b_wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", a_arready, 1'b0);
    check("rst_rvalid", a_rvalid, 1'b0);
    check("rst_bvalid", a_bvalid, 1'b0);
    check("rst_rdata", a_rdata, 32'h0);
    a_rst = 1'b1; b_rst = 1'b1;
    @(posedge clk); #1;
    check("idle_arready", a_arready, 1'b1);

    // Full-word write then readback
    a_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, rs, lat);
    check("wr1_bresp", rs, 2'b00);
    check("wr1_lat", lat, 1);
    a_read(32'h8000_0010, rd, rs, lat);
    check("rd1_data", rd, 32'hDEAD_BEEF);
    check("rd1_resp", rs, 2'b00);
    check("rd1_lat", lat, 1);

    // Partial strobes: bytes 0 and 2 only
    a_write(32'h8000_0010, 32'h1122_3344, 4'b0101, rs, lat);
    check("wr2_bresp", rs, 2'b00);
    a_read(32'h8000_0010, rd, rs, lat);
    check("rd2_data", rd, 32'hDE22_BE44);

    // Zero strobe is a no-op with OKAY; misaligned read hits containing word
    a_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, rs, lat);
    check("wr0_bresp", rs, 2'b00);
    a_read(32'h8000_0013, rd, rs, lat);
    check("rd_mis_data", rd, 32'hDE22_BE44);

    // Out-of-range accesses
    a_write(32'h8000_0000, 32'hCAFE_F00D, 4'b1111, rs, lat);
    a_read(32'h7FFF_FFFC, rd, rs, lat);
    check("rd_low_resp", rs, 2'b11);
    check("rd_low_data", rd, 32'h0);
    a_read(32'h8000_1000, rd, rs, lat);
    check("rd_high_resp", rs, 2'b11);
    check("rd_high_data", rd, 32'h0);
    a_write(32'h8000_1000, 32'h1234_5678, 4'b1111, rs, lat);
    check("wr_high_bresp", rs, 2'b11);
    a_read(32'h8000_0000, rd, rs, lat);
    check("word0_kept", rd, 32'hCAFE_F00D);
    a_read(32'h8000_0FFC, rd, rs, lat);
    check("rd_last_resp", rs, 2'b00);

    // Simultaneous read and write with R held off for 5 cycles
    a_araddr = 32'h8000_0010; a_arvalid = 1'b1;
    a_awaddr = 32'h8000_0004; a_wdata = 32'h55AA_55AA; a_wstrb = 4'hF;
    a_awvalid = 1'b1; a_wvalid = 1'b1; a_rready = 1'b0;
    check("pri_arready", a_arready, 1'b1);
    check("pri_awready", a_awready, 1'b0);
    check("pri_wready", a_wready, 1'b0);
    @(posedge clk); #1;
    a_arvalid = 1'b0;
    check("pri_rvalid", a_rvalid, 1'b1);
    check("pri_rdata", a_rdata, 32'hDE22_BE44);
    held = a_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_rvalid", a_rvalid, 1'b1);
      check("hold_rdata", a_rdata, held);
      check("hold_rresp", a_rresp, 2'b00);
      check("hold_arready", a_arready, 1'b0);
      check("hold_awready", a_awready, 1'b0);
      $display("A hold cycle %0d rvalid=%b rdata=%h", i, a_rvalid, a_rdata);
    end
    a_rready = 1'b1;
    @(posedge clk); #1;
    check("post_r_rvalid", a_rvalid, 1'b0);
    check("post_r_awready", a_awready, 1'b1);
    check("post_r_wready", a_wready, 1'b1);
    @(posedge clk); #1;
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    check("pri_bvalid", a_bvalid, 1'b1);
    check("pri_bresp", a_bresp, 2'b00);
    @(posedge clk); #1;
    a_read(32'h8000_0004, rd, rs, lat);
    check("pri_wr_data", rd, 32'h55AA_55AA);

    // Instance B: longer latencies, then reset mid-read
    b_write(32'h8000_0020, 32'h0BAD_C0DE, rs, lat);
    check("b_wr_bresp", rs, 2'b00);
    check("b_wr_lat", lat, 2);
    b_read(32'h8000_0020, rd, rs, lat);
    check("b_rd_data", rd, 32'h0BAD_C0DE);
    check("b_rd_lat", lat, 4);
    b_araddr = 32'h8000_0020; b_arvalid = 1'b1;
    @(posedge clk); #1;
    b_arvalid = 1'b0;
    @(posedge clk); #1;
    check("b_wait_rvalid", b_rvalid, 1'b0);
    b_rst = 1'b0;
    #1;
    check("b_rst_arready", b_arready, 1'b0);
    check("b_rst_rvalid", b_rvalid, 1'b0);
    check("b_rst_bvalid", b_bvalid, 1'b0);
    check("b_rst_awready", b_awready, 1'b0);
    check("b_rst_wready", b_wready, 1'b0);
    check("b_rst_rdata", b_rdata, 32'h0);
    check("b_rst_rresp", b_rresp, 2'b00);
    check("b_rst_bresp", b_bresp, 2'b00);
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    check("b_rel_arready", b_arready, 1'b1);
    saw_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b_rvalid) saw_rvalid = 1'b1;
      @(posedge clk); #1;
    end
    check("b_no_stale_rvalid", saw_rvalid, 1'b0);
    $display("B reset-in-RD_WAIT: stale rvalid seen=%b", saw_rvalid);
    b_read(32'h8000_0020, rd, rs, lat);
    check("b_after_rst_data", rd, 32'h0BAD_C0DE);
    check("b_after_rst_lat", lat, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_responder.md
Name: axi_lite_sram_responder

Overview:
- Memory-side responder for the core's fetch/load-store requests.
- Implements an AXI4-Lite slave backed by a word-addressed SRAM array, with configurable read and write latency.
- Replaces the combinational instruction/data memory model so the IFU and LSU can be moved to handshake-based access.
- Sits between the core's bus initiator and the simulation memory image.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for this revision.
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, first mapped byte address.
- RD_LAT, 1, cycles from the AR handshake to rvalid rising; minimum 1.
- WR_LAT, 1, cycles from the AW/W handshake to bvalid rising; minimum 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valid/ready outputs go to 0; rdata=0, rresp=0, bresp=0; latency counter=0.
  - Array contents are not reset.
  - Reset asserted mid-transaction drops the transaction; no response is issued after release.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE:
  - arready=1.
  - awready=wready=1 only when awvalid&&wvalid are both high and arvalid=0.
  - Reads have priority: with arvalid and awvalid&&wvalid in the same cycle, the read is accepted and the write waits.
  - A lone awvalid or lone wvalid is not accepted; both ready signals stay 0.
- Read path:
  - The AR handshake latches the address and loads the counter with RD_LAT-1, then enters RD_WAIT.
  - If RD_LAT=1, the FSM enters RD_RESP directly with rvalid=1 on the next cycle.
  - RD_WAIT decrements the counter; at 0 it moves to RD_RESP with rvalid=1.
  - rvalid therefore rises exactly RD_LAT cycles after the handshake cycle.
- Write path:
  - The AW+W handshake latches address, data and strobes, then enters WR_WAIT.
  - WR_WAIT counts down WR_LAT-1 the same way as the read path.
  - The array commit happens on the same edge that raises bvalid.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored, so misaligned accesses address the containing word.
  - Out of range means addr < BASE_ADDR or index >= DEPTH_WORDS.
  - Out-of-range read: rresp=11, rdata=0.
  - Out-of-range write: no array change, bresp=11.
  - The subtraction is ADDR_W-bit unsigned; wrap below BASE_ADDR is caught by the explicit compare.
- Write strobes:
  - Byte i is updated only when wstrb[i]=1.
  - wstrb=0 is a legal no-op and still returns OKAY.
- Response hold:
  - rdata/rresp are held stable while rvalid && !rready.
  - bresp is held stable while bvalid && !bready.
- Completion:
  - The R handshake (rvalid&&rready) clears rvalid, returns to IDLE, and the next AR may be accepted in the following cycle.
  - The B handshake behaves the same for bvalid.
- Only one outstanding transaction at a time; throughput is at most one access per RD_LAT+1 cycles.
- Read-after-write to the same address returns the new data, because the commit precedes bvalid.

Decomposition:
- Shared package holds:
  - resp encodings RESP_OKAY=2'b00 and RESP_DECERR=2'b11;
  - FSM state enum;
  - default BASE_ADDR constant, shared with the core's PC reset value.
- One natural sub-module: sram_word_array.
  - Synchronous write with byte enables; combinational read by index; no reset.
  - Keeps array storage separate from the handshake FSM.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x8000_0010 with wstrb=1111, then read it back:
  - bresp=00;
  - rdata=0xDEADBEEF, rresp=00;
  - rvalid rises exactly RD_LAT cycles after the AR handshake.
- Over 0xDEADBEEF at 0x8000_0010, write 0x11223344 with wstrb=0101, then read the same address:
  - rdata=0xDE22BE44.
- Read 0x7FFF_FFFC and read BASE_ADDR+4*DEPTH_WORDS (0x8000_1000):
  - rresp=11, rdata=0 for both.
  - A write to 0x8000_1000 returns bresp=11 and leaves word 0 unchanged.
- Drive arvalid, awvalid and wvalid in the same cycle:
  - AR is accepted first; awready/wready stay 0.
  - The write is accepted in the first IDLE cycle after the R handshake.
- Hold rready=0 for 5 cycles after rvalid rises:
  - rvalid stays 1 and rdata/rresp stay constant for all 5 cycles;
  - arready stays 0 until the R handshake completes.
- Deassert rst in RD_WAIT with RD_LAT=4, then release:
  - all outputs are 0 and the FSM is in IDLE;
  - no rvalid appears;
  - a subsequent read of a previously written word returns the old data.
